// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared geometry, tag-field layout and FSM state type for the dcache controller
package dcache_pkg;

   localparam int TAG_W    = 23;
   localparam int IDX_W    = 4;
   localparam int OFF_W    = 5;
   localparam int LINE_W   = 256;
   localparam int WORD_W   = 32;
   localparam int TAGF_W   = TAG_W + 2;

   // Positions inside the 25-bit SRAM tag field {valid, dirty, tag}
   localparam int VALID_BIT = 24;
   localparam int DIRTY_BIT = 23;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITEBACK,
      ST_READMISS,
      ST_REFILL
   } state_t;

endpackage

// File: rtl/dcache_word_merge.sv
// rtl/dcache_word_merge.sv - word select for loads and word replace for stores on a 256-bit line
//
// Ports:
//   line_i     : cache line (word k at bits [32k+31:32k])
//   word_sel_i : word index within the line
//   wdata_i    : store word
//   rdata_o    : selected word of line_i
//   merged_o   : line_i with the selected word replaced by wdata_i
module dcache_word_merge
   import dcache_pkg::*;
(
   input  logic [LINE_W-1:0] line_i,
   input  logic [2:0]        word_sel_i,
   input  logic [WORD_W-1:0] wdata_i,
   output logic [WORD_W-1:0] rdata_o,
   output logic [LINE_W-1:0] merged_o
);

   always_comb begin
      rdata_o  = line_i[{word_sel_i, 5'b0} +: WORD_W];
      merged_o = line_i;
      merged_o[{word_sel_i, 5'b0} +: WORD_W] = wdata_i;
   end

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - write-back 2-way dcache sequencing FSM (hit service, victim write-back, line fill)
//
// Optional feature: define DCACHE_STATS_EN to add access_cnt_o / miss_cnt_o.
//
// Ports:
//   clk_i, rst_i         : clock, asynchronous active-low reset
//   cpu_req_i/we_i       : CPU access request / store select
//   cpu_addr_i/data_i    : byte address (tag [31:9], index [8:5], word [4:2]) / store data
//   cpu_data_o, cpu_stall_o : load data / pipeline freeze
//   mem_enable_o/write_o : one-cycle request pulse / write-back select
//   mem_addr_o/data_o    : line address / write-back line
//   mem_data_i, mem_ack_i: fetched line / completion pulse
//   sram_addr_o/tag_o/data_o/enable_o/write_o : SRAM set index, tag field, line, enable, write strobe
//   sram_tag_i/data_i/hit_i : tag and data of hit way (or LRU victim), hit flag
//   access_cnt_o, miss_cnt_o : completed-access and miss counters (DCACHE_STATS_EN only)
module dcache_controller
   import dcache_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [31:0]       cpu_addr_i,
   input  logic [WORD_W-1:0] cpu_data_i,
   output logic [WORD_W-1:0] cpu_data_o,
   output logic              cpu_stall_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [31:0]       mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic [IDX_W-1:0]  sram_addr_o,
   output logic [TAGF_W-1:0] sram_tag_o,
   output logic [LINE_W-1:0] sram_data_o,
   output logic              sram_enable_o,
   output logic              sram_write_o,
   input  logic [TAGF_W-1:0] sram_tag_i,
   input  logic [LINE_W-1:0] sram_data_i,
   input  logic              sram_hit_i
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]       access_cnt_o,
   output logic [31:0]       miss_cnt_o
`endif
);

   state_t              state;
   logic [TAG_W-1:0]    victim_tag_q;
   logic [LINE_W-1:0]   victim_data_q;
   logic [LINE_W-1:0]   fill_data_q;
   logic [LINE_W-1:0]   merged_line;
   logic [TAG_W-1:0]    req_tag;
   logic [IDX_W-1:0]    req_idx;
   logic                idle_hit;
   logic                idle_miss;
   logic                addr_lsb_unused;

   assign req_tag         = cpu_addr_i[31:9];
   assign req_idx         = cpu_addr_i[8:5];
   assign addr_lsb_unused = ^cpu_addr_i[1:0];

   assign idle_hit  = (state == ST_IDLE) && cpu_req_i && sram_hit_i;
   assign idle_miss = (state == ST_IDLE) && cpu_req_i && !sram_hit_i;

   dcache_word_merge u_word_merge (
      .line_i     (sram_data_i),
      .word_sel_i (cpu_addr_i[4:2]),
      .wdata_i    (cpu_data_i),
      .rdata_o    (cpu_data_o),
      .merged_o   (merged_line)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state         <= ST_IDLE;
         mem_enable_o  <= 1'b0;
         mem_write_o   <= 1'b0;
         victim_tag_q  <= '0;
         victim_data_q <= '0;
         fill_data_q   <= '0;
      end else begin
         mem_enable_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (idle_miss) begin
                  // Victim must be captured now: the SRAM outputs are only
                  // valid for it while the missing address is presented.
                  victim_tag_q  <= sram_tag_i[TAG_W-1:0];
                  victim_data_q <= sram_data_i;
                  mem_enable_o  <= 1'b1;
                  if (sram_tag_i[VALID_BIT] && sram_tag_i[DIRTY_BIT]) begin
                     state       <= ST_WRITEBACK;
                     mem_write_o <= 1'b1;
                  end else begin
                     state       <= ST_READMISS;
                     mem_write_o <= 1'b0;
                  end
               end
            end
            ST_WRITEBACK: begin
               if (mem_ack_i) begin
                  state        <= ST_READMISS;
                  mem_enable_o <= 1'b1;
                  mem_write_o  <= 1'b0;
               end
            end
            ST_READMISS: begin
               if (mem_ack_i) begin
                  fill_data_q <= mem_data_i;
                  state       <= ST_REFILL;
               end
            end
            ST_REFILL: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   // Victim shares the set of the missing access, so its index is the request index.
   assign mem_addr_o = (state == ST_WRITEBACK) ? {victim_tag_q, req_idx, 5'b0}
                                               : {cpu_addr_i[31:5], 5'b0};
   assign mem_data_o = victim_data_q;

   assign sram_addr_o   = req_idx;
   assign sram_enable_o = cpu_req_i;
   assign sram_write_o  = rst_i && ((idle_hit && cpu_we_i) || (state == ST_REFILL));
   assign sram_tag_o    = (state == ST_REFILL) ? {1'b1, 1'b0, req_tag} : {1'b1, 1'b1, req_tag};
   assign sram_data_o   = (state == ST_REFILL) ? fill_data_q : merged_line;

   assign cpu_stall_o = (state != ST_IDLE) || (cpu_req_i && !sram_hit_i);

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         access_cnt_o <= '0;
         miss_cnt_o   <= '0;
      end else begin
         if (idle_hit)  access_cnt_o <= access_cnt_o + 32'd1;
         if (idle_miss) miss_cnt_o   <= miss_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - self-checking bench: table-driven hit vectors plus miss/reset sequences
module tb_dcache_controller;

   logic         clk_i;
   logic         rst_i;
   logic         cpu_req_i;
   logic         cpu_we_i;
   logic [31:0]  cpu_addr_i;
   logic [31:0]  cpu_data_i;
   logic [31:0]  cpu_data_o;
   logic         cpu_stall_o;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic [255:0] mem_data_i;
   logic         mem_ack_i;
   logic [3:0]   sram_addr_o;
   logic [24:0]  sram_tag_o;
   logic [255:0] sram_data_o;
   logic         sram_enable_o;
   logic         sram_write_o;
   logic [24:0]  sram_tag_i;
   logic [255:0] sram_data_i;
   logic         sram_hit_i;
`ifdef DCACHE_STATS_EN
   logic [31:0]  access_cnt_o;
   logic [31:0]  miss_cnt_o;
`endif

   dcache_controller dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .cpu_req_i     (cpu_req_i),
      .cpu_we_i      (cpu_we_i),
      .cpu_addr_i    (cpu_addr_i),
      .cpu_data_i    (cpu_data_i),
      .cpu_data_o    (cpu_data_o),
      .cpu_stall_o   (cpu_stall_o),
      .mem_enable_o  (mem_enable_o),
      .mem_write_o   (mem_write_o),
      .mem_addr_o    (mem_addr_o),
      .mem_data_o    (mem_data_o),
      .mem_data_i    (mem_data_i),
      .mem_ack_i     (mem_ack_i),
      .sram_addr_o   (sram_addr_o),
      .sram_tag_o    (sram_tag_o),
      .sram_data_o   (sram_data_o),
      .sram_enable_o (sram_enable_o),
      .sram_write_o  (sram_write_o),
      .sram_tag_i    (sram_tag_i),
      .sram_data_i   (sram_data_i),
      .sram_hit_i    (sram_hit_i)
`ifdef DCACHE_STATS_EN
      ,
      .access_cnt_o  (access_cnt_o),
      .miss_cnt_o    (miss_cnt_o)
`endif
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Line with word j = base + j, except word k (if 0..7) = w
   function automatic logic [255:0] mk_line(input logic [31:0] base, input int k, input logic [31:0] w);
      logic [255:0] l;
      for (int j = 0; j < 8; j++) l[j*32 +: 32] = (j == k) ? w : base + j;
      return l;
   endfunction

   typedef struct {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        hit;
      logic [31:0] base;
      logic        exp_stall;
      logic        exp_swr;
      logic [3:0]  exp_idx;
      logic [31:0] exp_rd;
      logic [24:0] exp_tag;
      int          exp_k;
   } vec_t;

   vec_t vecs[10];

   // Results of the last miss sequence
   int           stall_cycles;
   int           pulses;
   int           cnt;
   logic         wr_seen;
   logic         unstable;
   logic         done;
   logic [31:0]  p_addr[2];
   logic         p_write[2];
   logic [255:0] p_data[2];
   logic [31:0]  cur_addr;
   logic [24:0]  refill_tag;
   logic [255:0] refill_data;
   logic [31:0]  done_data;
   logic         done_swr;
   logic [24:0]  done_tag;
   logic [255:0] done_sline;

   // Issues one access that misses and plays memory (ack after lwb / lrd cycles)
   // and SRAM (hit with the refilled line after REFILL) until the stall drops.
   task automatic miss_seq(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input logic [24:0] vtag, input logic [255:0] vline,
                           input logic [255:0] fline, input int lwb, input int lrd);
      @(posedge clk_i); #1;
      cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = wdata;
      sram_hit_i = 1'b0; sram_tag_i = vtag; sram_data_i = vline; mem_ack_i = 1'b0;
      stall_cycles = 0; pulses = 0; cnt = 0; wr_seen = 1'b0; unstable = 1'b0; done = 1'b0;
      refill_tag = '0; refill_data = '0;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk_i);
         mem_ack_i = 1'b0;
         if (!cpu_stall_o) begin
            done       = 1'b1;
            done_data  = cpu_data_o;
            done_swr   = sram_write_o;
            done_tag   = sram_tag_o;
            done_sline = sram_data_o;
         end else begin
            stall_cycles++;
            if (mem_write_o) wr_seen = 1'b1;
            if (mem_enable_o) begin
               if (pulses < 2) begin
                  p_addr[pulses]  = mem_addr_o;
                  p_write[pulses] = mem_write_o;
                  p_data[pulses]  = mem_data_o;
               end
               pulses++;
               cnt = mem_write_o ? lwb : lrd;
               cur_addr = mem_addr_o;
            end else if (cnt > 0 && mem_addr_o !== cur_addr) begin
               unstable = 1'b1;
            end
            if (sram_write_o) begin
               refill_tag  = sram_tag_o;
               refill_data = sram_data_o;
               sram_hit_i  = 1'b1;
               sram_tag_i  = {1'b1, 1'b0, addr[31:9]};
               sram_data_i = fline;
            end
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  mem_ack_i  = 1'b1;
                  mem_data_i = fline;
               end
            end
         end
      end
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL miss_timeout: stall still high after 60 cycles for addr %h", addr);
      end
      mem_ack_i = 1'b0;
      @(posedge clk_i); #1;
      cpu_req_i = 1'b0; sram_hit_i = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b0, 32'h0000_0404, 32'h0,         1'b1, 32'hA000_0000, 1'b0, 1'b0, 4'h0, 32'hA000_0001, 25'h0,       -1};
      vecs[1] = '{1'b1, 1'b0, 32'h0000_1FFC, 32'h0,         1'b1, 32'hB000_0000, 1'b0, 1'b0, 4'hF, 32'hB000_0007, 25'h0,       -1};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_0003, 32'h0,         1'b1, 32'hC000_0000, 1'b0, 1'b0, 4'h0, 32'hC000_0000, 25'h0,       -1};
      vecs[3] = '{1'b1, 1'b1, 32'h0000_0408, 32'h1234_5678, 1'b1, 32'hD000_0000, 1'b0, 1'b1, 4'h0, 32'h0,          25'h1800002, 2};
      vecs[4] = '{1'b1, 1'b1, 32'hFFFF_FFE0, 32'h8765_4321, 1'b1, 32'hE000_0000, 1'b0, 1'b1, 4'hF, 32'h0,          25'h1FFFFFF, 0};
      vecs[5] = '{1'b1, 1'b1, 32'h0000_01BC, 32'h0BAD_F00D, 1'b1, 32'h1000_0000, 1'b0, 1'b1, 4'hD, 32'h0,          25'h1800000, 7};
      vecs[6] = '{1'b1, 1'b0, 32'h0000_0404, 32'h0,         1'b0, 32'h2000_0000, 1'b1, 1'b0, 4'h0, 32'h0,          25'h0,       -1};
      vecs[7] = '{1'b1, 1'b1, 32'h0000_0404, 32'h5555_AAAA, 1'b0, 32'h3000_0000, 1'b1, 1'b0, 4'h0, 32'h0,          25'h0,       -1};
      vecs[8] = '{1'b0, 1'b1, 32'h0000_0404, 32'h5555_AAAA, 1'b1, 32'h4000_0000, 1'b0, 1'b0, 4'h0, 32'h0,          25'h0,       -1};
      vecs[9] = '{1'b0, 1'b0, 32'h0000_01A0, 32'h0,         1'b0, 32'h4100_0000, 1'b0, 1'b0, 4'hD, 32'h0,          25'h0,       -1};

      rst_i = 1'b0; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
      mem_data_i = '0; mem_ack_i = 1'b0; sram_tag_i = '0; sram_data_i = '0; sram_hit_i = 1'b0;

      // Reset state
      repeat (2) @(negedge clk_i);
      chk("rst_mem_enable", mem_enable_o, 1'b0);
      chk("rst_mem_write",  mem_write_o,  1'b0);
      chk("rst_sram_write", sram_write_o, 1'b0);
      chk("rst_stall",      cpu_stall_o,  1'b0);
      rst_i = 1'b1;

      // Table: IDLE-state decode, hits and miss detection (request dropped before the edge)
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_i); #1;
         cpu_req_i = vecs[i].req; cpu_we_i = vecs[i].we; cpu_addr_i = vecs[i].addr;
         cpu_data_i = vecs[i].wdata; sram_hit_i = vecs[i].hit; sram_tag_i = 25'h1000000;
         sram_data_i = mk_line(vecs[i].base, -1, 32'h0);
         @(negedge clk_i);
         chk($sformatf("v%0d_stall", i), cpu_stall_o, vecs[i].exp_stall);
         chk($sformatf("v%0d_sram_write", i), sram_write_o, vecs[i].exp_swr);
         chk($sformatf("v%0d_sram_addr", i), sram_addr_o, vecs[i].exp_idx);
         chk($sformatf("v%0d_sram_enable", i), sram_enable_o, vecs[i].req);
         if (vecs[i].req && vecs[i].hit && !vecs[i].we)
            chk($sformatf("v%0d_load_data", i), cpu_data_o, vecs[i].exp_rd);
         if (vecs[i].exp_swr) begin
            chk($sformatf("v%0d_store_tag", i), sram_tag_o, vecs[i].exp_tag);
            chk($sformatf("v%0d_store_line", i), sram_data_o,
                mk_line(vecs[i].base, vecs[i].exp_k, vecs[i].wdata));
         end
         cpu_req_i = 1'b0;
      end

      // Cold load miss at 0x404, read latency 3
      miss_seq(32'h0000_0404, 1'b0, 32'h0, 25'h0, mk_line(32'h0, -1, 32'h0),
               mk_line(32'hF000_0000, 1, 32'hDEAD_BEEF), 0, 3);
      chk("cold_pulses",     pulses, 1);
      chk("cold_addr",       p_addr[0], 32'h0000_0400);
      chk("cold_write",      p_write[0], 1'b0);
      chk("cold_wr_seen",    wr_seen, 1'b0);
      chk("cold_stall_cyc",  stall_cycles, 5);
      chk("cold_refill_tag", refill_tag, 25'h1000002);
      chk("cold_refill_line", refill_data, mk_line(32'hF000_0000, 1, 32'hDEAD_BEEF));
      chk("cold_load_data",  done_data, 32'hDEAD_BEEF);

      // Store hit to the refilled line
      @(posedge clk_i); #1;
      cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h0000_0404; cpu_data_i = 32'h1234_5678;
      sram_hit_i = 1'b1; sram_tag_i = 25'h1000002; sram_data_i = mk_line(32'hF000_0000, 1, 32'hDEAD_BEEF);
      @(negedge clk_i);
      chk("st_stall",      cpu_stall_o, 1'b0);
      chk("st_sram_write", sram_write_o, 1'b1);
      chk("st_tag",        sram_tag_o, 25'h1800002);
      chk("st_line",       sram_data_o, mk_line(32'hF000_0000, 1, 32'h1234_5678));
      @(posedge clk_i); #1;
      cpu_req_i = 1'b0; sram_hit_i = 1'b0;

      // Dirty victim (line 0x200) on load 0x400: write-back then read
      miss_seq(32'h0000_0400, 1'b0, 32'h0, 25'h1800001, mk_line(32'h5000_0000, -1, 32'h0),
               mk_line(32'h6000_0000, -1, 32'h0), 2, 4);
      chk("dirty_pulses",    pulses, 2);
      chk("dirty_wb_write",  p_write[0], 1'b1);
      chk("dirty_wb_addr",   p_addr[0], 32'h0000_0200);
      chk("dirty_wb_data",   p_data[0], mk_line(32'h5000_0000, -1, 32'h0));
      chk("dirty_rd_write",  p_write[1], 1'b0);
      chk("dirty_rd_addr",   p_addr[1], 32'h0000_0400);
      chk("dirty_stall_cyc", stall_cycles, 8);
      chk("dirty_addr_hold", unstable, 1'b0);
      chk("dirty_load_data", done_data, 32'h6000_0000);

      // Clean valid victim, store miss at 0xC24, read latency 1
      miss_seq(32'h0000_0C24, 1'b1, 32'hA5A5_5A5A, 25'h1000009, mk_line(32'h7000_0000, -1, 32'h0),
               mk_line(32'h8000_0000, 1, 32'hCAFE_F00D), 0, 1);
      chk("clean_pulses",     pulses, 1);
      chk("clean_wr_seen",    wr_seen, 1'b0);
      chk("clean_addr",       p_addr[0], 32'h0000_0C20);
      chk("clean_stall_cyc",  stall_cycles, 3);
      chk("clean_refill_tag", refill_tag, 25'h1000006);
      chk("clean_refill_line", refill_data, mk_line(32'h8000_0000, 1, 32'hCAFE_F00D));
      chk("clean_st_write",   done_swr, 1'b1);
      chk("clean_st_tag",     done_tag, 25'h1800006);
      chk("clean_st_line",    done_sline, mk_line(32'h8000_0000, 1, 32'hA5A5_5A5A));

      // Reset asserted during READMISS, then a late ack
      @(posedge clk_i); #1;
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0404;
      sram_hit_i = 1'b0; sram_tag_i = 25'h0; sram_data_i = '0;
      @(negedge clk_i);
      chk("mrst_detect_stall", cpu_stall_o, 1'b1);
      @(negedge clk_i);
      chk("mrst_pre_enable", mem_enable_o, 1'b1);
      rst_i = 1'b0; cpu_req_i = 1'b0;
      #1;
      chk("mrst_enable",     mem_enable_o, 1'b0);
      chk("mrst_write",      mem_write_o, 1'b0);
      chk("mrst_stall",      cpu_stall_o, 1'b0);
      chk("mrst_sram_write", sram_write_o, 1'b0);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; sram_hit_i = 1'b1;
      sram_data_i = mk_line(32'h9000_0000, -1, 32'h0);
      mem_ack_i = 1'b1; mem_data_i = mk_line(32'hBAD0_0000, -1, 32'h0);
      @(negedge clk_i);
      chk("late_ack_stall",  cpu_stall_o, 1'b0);
      chk("late_ack_swr0",   sram_write_o, 1'b0);
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
      @(negedge clk_i);
      chk("late_ack_swr1",   sram_write_o, 1'b0);
      chk("late_ack_enable", mem_enable_o, 1'b0);
      chk("late_ack_stall1", cpu_stall_o, 1'b0);
      chk("late_ack_data",   cpu_data_o, 32'h9000_0001);
      @(posedge clk_i); #1;
      cpu_req_i = 1'b0; sram_hit_i = 1'b0;

`ifdef DCACHE_STATS_EN
      // Counters: 3 hits then 1 miss (whose retry is the 4th completed access)
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      chk("stats_rst_access", access_cnt_o, 32'd0);
      chk("stats_rst_miss",   miss_cnt_o, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i); #1;
         cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = i * 4; sram_hit_i = 1'b1;
         @(negedge clk_i);
         chk($sformatf("stats_hit%0d_stall", i), cpu_stall_o, 1'b0);
      end
      miss_seq(32'h0000_0404, 1'b0, 32'h0, 25'h0, '0, mk_line(32'h1100_0000, -1, 32'h0), 0, 2);
      @(negedge clk_i);
      chk("stats_access", access_cnt_o, 32'd4);
      chk("stats_miss",   miss_cnt_o, 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Sequencing controller for the 2-way set-associative, write-back data cache (`dcache_sram`), placed between the CPU MEM stage and the 256-bit-line data memory.
- Decodes 32-bit CPU word accesses.
- Serves hits with zero wait states.
- On a miss: writes back a dirty victim line, fetches the new line, refills the SRAM, then completes the access.
- Stalls the pipeline for the full duration of every miss.

## Interface
Parameters: none. Geometry is fixed by the package constants below.

Clock and reset:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-low.

CPU side:
- `cpu_req_i` in 1: access request. Address, data and write-enable are held stable while `cpu_stall_o` is high.
- `cpu_we_i` in 1: 1 = store, 0 = load.
- `cpu_addr_i` in 32: byte address. Fields are tag [31:9], index [8:5], word [4:2]; [1:0] is ignored.
- `cpu_data_i` in 32: store data.
- `cpu_data_o` out 32: load data, valid when `cpu_req_i` is high and `cpu_stall_o` is low.
- `cpu_stall_o` out 1: freeze pipeline.

Memory side:
- `mem_enable_o` out 1: one-cycle request pulse.
- `mem_write_o` out 1: 1 = line write-back.
- `mem_addr_o` out 32: line address, bits [4:0] = 0.
- `mem_data_o` out 256: write-back line.
- `mem_data_i` in 256: fetched line, valid in the `mem_ack_i` cycle.
- `mem_ack_i` in 1: one-cycle completion pulse.

SRAM side:
- `sram_addr_o` out 4: set index.
- `sram_tag_o` out 25: [24] valid, [23] dirty, [22:0] tag.
- `sram_data_o` out 256: line to write.
- `sram_enable_o` out 1: SRAM enable.
- `sram_write_o` out 1: SRAM write strobe.
- `sram_tag_i` in 25: tag of hit way, or LRU victim on miss.
- `sram_data_i` in 256: data of hit way, or LRU victim on miss.
- `sram_hit_i` in 1: hit indication.

## Operation
- `sram_addr_o` is always `cpu_addr_i[8:5]`. `sram_enable_o` = `cpu_req_i`.
- Word k of a line occupies bits [32k+31:32k].
- FSM states: IDLE, WRITEBACK, READMISS, REFILL.
- IDLE, `cpu_req_i` & `sram_hit_i`:
  - Load: `cpu_data_o` = selected word of `sram_data_i`.
  - Store: `sram_write_o` = 1, `sram_data_o` = `sram_data_i` with the selected word replaced by `cpu_data_i`, `sram_tag_o` = {1,1,tag}.
  - No stall. Stay in IDLE.
- IDLE, `cpu_req_i` & ~`sram_hit_i`: stall.
  - If `sram_tag_i[24]` & `sram_tag_i[23]`, go to WRITEBACK.
  - Otherwise go to READMISS.
  - The victim tag/data are latched into registers on this transition.
- WRITEBACK:
  - `mem_write_o` = 1, `mem_addr_o` = {victim tag, index, 5'b0}, `mem_data_o` = latched victim data.
  - On `mem_ack_i`, go to READMISS.
- READMISS:
  - `mem_write_o` = 0, `mem_addr_o` = {`cpu_addr_i[31:5]`, 5'b0}.
  - On `mem_ack_i`, latch `mem_data_i` and go to REFILL.
- REFILL (one cycle):
  - `sram_write_o` = 1, `sram_data_o` = latched line, `sram_tag_o` = {1,0,tag}.
  - The SRAM replaces its LRU way.
  - Go to IDLE. The retried access then hits; a store sets the dirty bit there.
- `cpu_stall_o` = (state≠IDLE) | (`cpu_req_i` & ~`sram_hit_i`).
- `mem_enable_o` is registered: high only in the first cycle of WRITEBACK and of READMISS.
- `mem_addr_o`, `mem_write_o` and `mem_data_o` are held stable until `mem_ack_i`.
- `mem_ack_i` is ignored in IDLE and REFILL.
- `sram_write_o` is never high outside an IDLE store hit or REFILL.

## Timing
- Reset (`rst_i` low, at any time, including mid-miss):
  - State returns to IDLE immediately.
  - `mem_enable_o`, `mem_write_o`, `sram_write_o` = 0; latched registers = 0.
  - Any pending memory transaction is abandoned. Combinational outputs follow their IDLE equations.
- Hit latency: 0 cycles. A store commits at the next posedge.
- Clean miss: 1 detect cycle + (memory latency L) cycles in READMISS + 1 REFILL cycle. The access completes in the following IDLE cycle, so total stall is L+2 cycles.
- Dirty miss adds L′ cycles in WRITEBACK.
- Back-to-back hits complete one per cycle.
- A miss to the same set as a just-refilled line evicts the other way, per the SRAM's LRU policy.

## Configuration
- `DCACHE_STATS_EN`: adds outputs `access_cnt_o` [31:0] and `miss_cnt_o` [31:0].
  - `access_cnt_o` increments on each completed access (IDLE & `cpu_req_i` & `sram_hit_i`).
  - `miss_cnt_o` increments on each IDLE→WRITEBACK/READMISS transition.
  - Both counters wrap and reset to 0.
- Without the macro, these ports and counters do not exist.

## Structure
- Package `dcache_pkg` holds:
  - State enum.
  - `TAG_W`=23, `IDX_W`=4, `OFF_W`=5, `LINE_W`=256.
  - Tag-field bit positions `VALID_BIT`=24, `DIRTY_BIT`=23.
- One natural sub-module, `dcache_word_merge` (combinational): read word select and store word merge, used for both the load path and the store path.

## Test plan
- Reset, then load 0x0000_0404 (cold): mem read at 0x400 after 1 cycle. Ack returns a line with word1 = 0xDEADBEEF. REFILL writes tag {1,0,0x2}; next cycle `cpu_data_o` = 0xDEADBEEF, stall low.
- Store 0x1234_5678 to 0x404 after that refill: no stall, SRAM write, tag dirty bit = 1, line word1 updated, other words unchanged.
- Fill both ways of set 0 dirty (0x000, 0x200), then load 0x400: WRITEBACK to the LRU line address with its data, then READMISS at 0x400. `mem_enable_o` pulses exactly twice.
- Clean victim miss: no WRITEBACK state, and `mem_write_o` stays 0 throughout.
- Assert `rst_i` low during READMISS: next cycle state is IDLE and `mem_enable_o` = 0. A late `mem_ack_i` causes no SRAM write.
- With `DCACHE_STATS_EN`: 3 hits + 1 miss sequence gives `access_cnt_o` = 4, `miss_cnt_o` = 1.
